wb_pipe_latch: RTL and testbench

Parametrised MEM/WB pipeline register for the MIPS pipeline, successor to the fixed-width MEM/WB latch. It adds:
- valid/ready handshaking;
- a two-entry skid buffer, so the WB stage can stall without a combinational ready path back into MEM;
- a flush input;
- a write-back result mux;
- a saturating back-pressure counter.

It sits between the data-memory stage and the register-file write port.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/sat_counter.sv | 30 +++
 rtl/wb_pipe_latch.sv | 122 ++++++++++++
 tb/tb_wb_pipe_latch.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the MEM/WB pipeline latch: default payload record and occupancy states.
package wb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef struct packed {
    logic [DATA_W-1:0] aluresult;
    logic [DATA_W-1:0] readdata;
    logic [REG_W-1:0]  writereg;
    logic              regwrite;
    logic              memtoreg;
  } wb_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } wb_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/wb_pipe_latch.sv
// MEM/WB pipeline register with a two-entry skid buffer, flush, result mux and stall counter.
module wb_pipe_latch
  import wb_pkg::wb_state_t, wb_pkg::EMPTY, wb_pkg::ONE, wb_pkg::FULL;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              valid_MEM,
  output logic              ready_MEM,
  input  logic [DATA_W-1:0] aluresult_MEM,
  input  logic [DATA_W-1:0] readdata_MEM,
  input  logic [REG_W-1:0]  writereg_MEM,
  input  logic              regwrite_MEM,
  input  logic              memtoreg_MEM,
  output logic              valid_WB,
  input  logic              ready_WB,
  output logic [DATA_W-1:0] aluresult_WB,
  output logic [DATA_W-1:0] readdata_WB,
  output logic [REG_W-1:0]  writereg_WB,
  output logic              regwrite_WB,
  output logic [DATA_W-1:0] result_WB,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] aluresult;
    logic [DATA_W-1:0] readdata;
    logic [REG_W-1:0]  writereg;
    logic              regwrite;
    logic              memtoreg;
  } entry_t;

  wb_state_t state_q, state_d;
  entry_t    main_q, main_d;
  entry_t    skid_q, skid_d;
  entry_t    in_entry;
  logic      in_fire, out_fire;

  assign in_entry = '{
    aluresult: aluresult_MEM,
    readdata:  readdata_MEM,
    writereg:  writereg_MEM,
    regwrite:  regwrite_MEM,
    memtoreg:  memtoreg_MEM
  };

  // Ready comes from registered state only, so WB stalls never reach back into MEM.
  assign ready_MEM = (state_q != FULL) & ~flush & reset;
  assign valid_WB  = (state_q != EMPTY);
  assign in_fire   = valid_MEM & ready_MEM;
  assign out_fire  = valid_WB & ready_WB;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_entry;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_entry;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = in_entry;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign aluresult_WB = main_q.aluresult;
  assign readdata_WB  = main_q.readdata;
  assign writereg_WB  = main_q.writereg;
  assign regwrite_WB  = main_q.regwrite & valid_WB;
  assign result_WB    = main_q.memtoreg ? main_q.readdata : main_q.aluresult;

  // Flush leaves the count alone; only reset clears it.
  sat_counter #(
    .Width (CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk),
    .clr_ni (reset),
    .en_i   ((state_q == FULL) && !out_fire),
    .cnt_o  (stall_cnt)
  );

endmodule

// File: tb/tb_wb_pipe_latch.sv
// Self-checking bench for wb_pipe_latch: occupancy model plus FIFO scoreboard, table-driven result mux.
module tb_wb_pipe_latch;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush, valid_MEM, ready_WB, regwrite_MEM, memtoreg_MEM;
  logic [DW-1:0] aluresult_MEM, readdata_MEM;
  logic [RW-1:0] writereg_MEM;

  logic          ready_MEM, valid_WB, regwrite_WB;
  logic [DW-1:0] aluresult_WB, readdata_WB, result_WB;
  logic [RW-1:0] writereg_WB;
  logic [CW-1:0] stall_cnt;

  logic          u2_ready_MEM, u2_valid_WB, u2_regwrite_WB;
  logic [DW-1:0] u2_aluresult_WB, u2_readdata_WB, u2_result_WB;
  logic [RW-1:0] u2_writereg_WB;
  logic [1:0]    u2_stall_cnt;

  wb_pipe_latch #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .valid_MEM(valid_MEM), .ready_MEM(ready_MEM),
    .aluresult_MEM(aluresult_MEM), .readdata_MEM(readdata_MEM), .writereg_MEM(writereg_MEM),
    .regwrite_MEM(regwrite_MEM), .memtoreg_MEM(memtoreg_MEM), .valid_WB(valid_WB),
    .ready_WB(ready_WB), .aluresult_WB(aluresult_WB), .readdata_WB(readdata_WB),
    .writereg_WB(writereg_WB), .regwrite_WB(regwrite_WB), .result_WB(result_WB),
    .stall_cnt(stall_cnt)
  );

  wb_pipe_latch #(.DATA_W(DW), .REG_W(RW), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .flush(flush), .valid_MEM(valid_MEM), .ready_MEM(u2_ready_MEM),
    .aluresult_MEM(aluresult_MEM), .readdata_MEM(readdata_MEM), .writereg_MEM(writereg_MEM),
    .regwrite_MEM(regwrite_MEM), .memtoreg_MEM(memtoreg_MEM), .valid_WB(u2_valid_WB),
    .ready_WB(ready_WB), .aluresult_WB(u2_aluresult_WB), .readdata_WB(u2_readdata_WB),
    .writereg_WB(u2_writereg_WB), .regwrite_WB(u2_regwrite_WB), .result_WB(u2_result_WB),
    .stall_cnt(u2_stall_cnt)
  );

  typedef struct {
    logic [DW-1:0] alu;
    logic [DW-1:0] rd;
    logic [RW-1:0] wr;
    logic          rw;
    logic [DW-1:0] res;
  } exp_t;

  typedef struct {
    logic          m2r;
    logic          rw;
    logic [RW-1:0] wr;
    logic [DW-1:0] alu;
    logic [DW-1:0] rd;
    logic [DW-1:0] res;
  } vec_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned exp_stall = 0;
  int unsigned exp_stall2 = 0;
  bit          zeroed = 1'b1;
  bit          use_tbl = 1'b0;
  logic [DW-1:0] tbl_res = '0;
  int unsigned saved_stall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] alu, input logic [DW-1:0] rd,
                       input logic [RW-1:0] wr, input bit rw, input bit m2r);
    valid_MEM     = v;
    aluresult_MEM = alu;
    readdata_MEM  = rd;
    writereg_MEM  = wr;
    regwrite_MEM  = rw;
    memtoreg_MEM  = m2r;
  endtask

  // Check current outputs against the model, advance the model over one edge, then step past it.
  task automatic tick();
    bit   exp_rdy, in_f, out_f;
    exp_t e;
    #1;
    exp_rdy = (sb.size() != 2) && !flush && reset;
    check("ready_MEM", {63'd0, ready_MEM}, {63'd0, exp_rdy});
    check("valid_WB", {63'd0, valid_WB}, {63'd0, sb.size() != 0});
    if (sb.size() != 0) begin
      check("result_WB", {32'd0, result_WB}, {32'd0, sb[0].res});
      check("aluresult_WB", {32'd0, aluresult_WB}, {32'd0, sb[0].alu});
      check("readdata_WB", {32'd0, readdata_WB}, {32'd0, sb[0].rd});
      check("writereg_WB", {59'd0, writereg_WB}, {59'd0, sb[0].wr});
      check("regwrite_WB", {63'd0, regwrite_WB}, {63'd0, sb[0].rw});
    end else begin
      check("regwrite_WB_idle", {63'd0, regwrite_WB}, 64'd0);
      if (zeroed) begin
        check("payload_zero", {aluresult_WB, readdata_WB ^ result_WB ^ {27'd0, writereg_WB}},
              64'd0);
        check("result_zero", {32'd0, result_WB}, 64'd0);
      end
    end
    check("stall_cnt", {48'd0, stall_cnt}, {32'd0, exp_stall});
    check("stall_cnt_w2", {62'd0, u2_stall_cnt}, {32'd0, exp_stall2});

    in_f  = valid_MEM && exp_rdy;
    out_f = (sb.size() != 0) && ready_WB;
    if (!reset) begin
      exp_stall  = 0;
      exp_stall2 = 0;
    end else if (sb.size() == 2 && !out_f) begin
      if (exp_stall < 65535) exp_stall++;
      if (exp_stall2 < 3) exp_stall2++;
    end
    if (!reset || flush) begin
      sb.delete();
      zeroed = 1'b1;
    end else begin
      if (out_f) void'(sb.pop_front());
      if (in_f) begin
        e.alu = aluresult_MEM;
        e.rd  = readdata_MEM;
        e.wr  = writereg_MEM;
        e.rw  = regwrite_MEM;
        e.res = use_tbl ? tbl_res : (memtoreg_MEM ? readdata_MEM : aluresult_MEM);
        sb.push_back(e);
        zeroed = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 5'd3,  32'h0000_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b1, 5'd7,  32'h0000_0004, 32'hDEAD_BEEF, 32'h0000_0004};
    vecs[2] = '{1'b1, 1'b0, 5'd31, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    vecs[3] = '{1'b0, 1'b1, 5'd0,  32'h1234_5678, 32'h8765_4321, 32'h1234_5678};
    vecs[4] = '{1'b1, 1'b1, 5'd16, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h5A5A_5A5A};
    vecs[5] = '{1'b0, 1'b0, 5'd1,  32'h8000_0000, 32'h0000_0001, 32'h8000_0000};

    reset    = 1'b0;
    flush    = 1'b0;
    ready_WB = 1'b1;
    drive(1'b1, 32'h99, 32'h0, 5'd9, 1'b1, 1'b0);
    @(posedge clk);
    #1;

    // Reset held two cycles with valid_MEM high.
    tick();
    tick();
    check("reset_stall_cnt", {48'd0, stall_cnt}, 64'd0);
    reset = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    tick();

    // Streaming 1..8 with ready_WB held high.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), DW'(i * 3), RW'(i), i[0], 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    tick();
    tick();

    // Table-driven result mux.
    use_tbl = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tbl_res = vecs[i].res;
      drive(1'b1, vecs[i].alu, vecs[i].rd, vecs[i].wr, vecs[i].rw, vecs[i].m2r);
      tick();
    end
    use_tbl = 1'b0;
    drive(1'b0, 32'h4, 32'hDEAD_BEEF, 5'd2, 1'b1, 1'b1);
    tick();
    tick();

    // Back-pressure: A, B, C with WB stalled; also exercises the stall counter.
    drive(1'b1, 32'h10, 32'h0, 5'd1, 1'b1, 1'b0);
    tick();
    ready_WB = 1'b0;
    drive(1'b1, 32'h20, 32'h0, 5'd2, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h30, 32'h0, 5'd3, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check("stall_after_5", {48'd0, stall_cnt}, 64'd5);
    check("stall_w2_after_5", {62'd0, u2_stall_cnt}, 64'd3);
    check("held_head_A", {32'd0, result_WB}, 64'h10);
    for (int i = 0; i < 5; i++) tick();
    check("stall_after_10", {48'd0, stall_cnt}, 64'd10);
    check("stall_w2_sat", {62'd0, u2_stall_cnt}, 64'd3);
    ready_WB = 1'b1;
    tick();
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    tick();
    tick();
    check("bp_drained", {63'd0, valid_WB}, 64'd0);

    // Flush in FULL while MEM offers an entry.
    ready_WB = 1'b0;
    drive(1'b1, 32'h40, 32'h0, 5'd4, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h50, 32'h0, 5'd5, 1'b1, 1'b1);
    tick();
    saved_stall = exp_stall;
    ready_WB = 1'b1;
    flush    = 1'b1;
    drive(1'b1, 32'h60, 32'h77, 5'd6, 1'b1, 1'b0);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    check("flush_valid", {63'd0, valid_WB}, 64'd0);
    check("flush_regwrite", {63'd0, regwrite_WB}, 64'd0);
    check("flush_alu_zero", {32'd0, aluresult_WB}, 64'd0);
    check("flush_stall_kept", {48'd0, stall_cnt}, {32'd0, saved_stall});
    tick();
    tick();

    // Reset mid-operation clears entries and stall counter.
    ready_WB = 1'b0;
    drive(1'b1, 32'h70, 32'h0, 5'd7, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h80, 32'h0, 5'd8, 1'b1, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    check("midreset_stall", {48'd0, stall_cnt}, 64'd0);
    check("midreset_valid", {63'd0, valid_WB}, 64'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
